// File: rtl/barcode_rcv.sv
// barcode_rcv
//   Receives the self-clocked station-ID barcode waveform sent by
//   barcode_mimic and decodes it into an 8-bit ID.
//
//   The start bit's low time defines the bit period T. Each data bit
//   (8 bits, MSB first) begins with a falling edge. The bit is read by
//   sampling the line T clocks after that falling edge. A frame whose
//   two upper bits are not zero is illegal and is dropped.
//
// Ports
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   BC         : raw serial line, asynchronous to clk, idles high
//   clr_ID_vld : consumer acknowledge; clears ID_vld
//   ID         : last accepted station ID
//   ID_vld     : sticky flag, a new legal ID is held in ID
//   busy       : high while a frame is in progress (state != IDLE)
module barcode_rcv #(
  parameter int unsigned     PW      = 22,
  parameter logic [PW-1:0]   TIMEOUT = 22'h3F_FFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       BC,
  input  logic       clr_ID_vld,
  output logic [7:0] ID,
  output logic       ID_vld,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_FALL,
    SAMPLE,
    CHECK
  } state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   period_reg, period_next;
  logic [PW-1:0]   t_reg, t_next;
  logic [PW-1:0]   timer_reg, timer_next;
  logic [3:0]      bit_cnt_reg, bit_cnt_next;
  logic [7:0]      shreg_reg, shreg_next;
  logic [7:0]      id_reg, id_next;
  logic            id_vld_reg, id_vld_next;

  // Two-flop synchronizer plus one history flop. All preset to the
  // idle (high) level so reset never produces a spurious falling edge.
  logic bc_meta_reg, bc_sync_reg, bc_prev_reg;
  logic fall;

  assign fall = bc_prev_reg & ~bc_sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bc_meta_reg <= 1'b1;
      bc_sync_reg <= 1'b1;
      bc_prev_reg <= 1'b1;
      state_reg   <= IDLE;
      period_reg  <= '0;
      t_reg       <= '0;
      timer_reg   <= '0;
      bit_cnt_reg <= '0;
      shreg_reg   <= '0;
      id_reg      <= '0;
      id_vld_reg  <= 1'b0;
    end else begin
      bc_meta_reg <= BC;
      bc_sync_reg <= bc_meta_reg;
      bc_prev_reg <= bc_sync_reg;
      state_reg   <= state_next;
      period_reg  <= period_next;
      t_reg       <= t_next;
      timer_reg   <= timer_next;
      bit_cnt_reg <= bit_cnt_next;
      shreg_reg   <= shreg_next;
      id_reg      <= id_next;
      id_vld_reg  <= id_vld_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    period_next  = period_reg;
    t_next       = t_reg;
    timer_next   = timer_reg;
    bit_cnt_next = bit_cnt_reg;
    shreg_next   = shreg_reg;
    id_next      = id_reg;
    // A set in CHECK below overrides this clear, so set wins on collision.
    id_vld_next  = clr_ID_vld ? 1'b0 : id_vld_reg;

    case (state_reg)
      IDLE: begin
        if (fall) begin
          state_next  = START;
          period_next = {{(PW-1){1'b0}}, 1'b1};
        end
      end

      START: begin
        if (bc_sync_reg) begin
          // End of start bit: its low time is the bit period.
          t_next       = period_reg;
          bit_cnt_next = '0;
          timer_next   = '0;
          state_next   = WAIT_FALL;
        end else if (period_reg == {PW{1'b1}}) begin
          // Line stuck low: abandon.
          state_next = IDLE;
        end else begin
          period_next = period_reg + 1'b1;
        end
      end

      WAIT_FALL: begin
        if (fall) begin
          timer_next = {{(PW-1){1'b0}}, 1'b1};
          state_next = SAMPLE;
        end else if (timer_reg == TIMEOUT) begin
          state_next = IDLE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      SAMPLE: begin
        // Falling edges here are ignored; only the timer decides.
        if (timer_reg == t_reg) begin
          shreg_next   = {shreg_reg[6:0], bc_sync_reg};
          bit_cnt_next = bit_cnt_reg + 4'd1;
          timer_next   = '0;
          state_next   = (bit_cnt_reg == 4'd7) ? CHECK : WAIT_FALL;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      CHECK: begin
        if (shreg_reg[7:6] == 2'b00) begin
          id_next     = shreg_reg;
          id_vld_next = 1'b1;
        end
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign ID     = id_reg;
  assign ID_vld = id_vld_reg;
  assign busy   = (state_reg != IDLE);

endmodule
